// File: rtl/key_count_pkg.sv
// Shared constants for the key-driven count source feeding bcd2driver.
package key_count_pkg;
   localparam int   CNT_W_DEFAULT  = 7;
   localparam int   SYNC_STAGES    = 2;
   localparam logic KEY_RELEASED   = 1'b1;
   localparam int   DEBOUNCE_SIM   = 4;
   localparam int   DEBOUNCE_BOARD = 500000;
endpackage

// File: rtl/key_debounce.sv
// Two-flop synchronizer, stable-level debounce and press (1->0) pulse for one
// active-low pushbutton.
module key_debounce
   import key_count_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_SIM
) (
   input  logic clock,
   input  logic reset_n,
   input  logic raw_n,
   output logic level,
   output logic press_pulse
);

   localparam int DB_W = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s2;
   logic [DB_W-1:0]        db_cnt;

   assign s2 = sync_q[SYNC_STAGES-1];

   // The counter only advances while s2 disagrees with the accepted level, so
   // any return to the accepted level restarts the qualification window.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sync_q      <= {SYNC_STAGES{KEY_RELEASED}};
         level       <= KEY_RELEASED;
         db_cnt      <= '0;
         press_pulse <= 1'b0;
      end else begin
         sync_q      <= {sync_q[SYNC_STAGES-2:0], raw_n};
         press_pulse <= 1'b0;
         if (s2 == level) begin
            db_cnt <= '0;
         end else if (db_cnt == DB_LAST) begin
            level       <= s2;
            db_cnt      <= '0;
            press_pulse <= (s2 != KEY_RELEASED);
         end else begin
            db_cnt <= db_cnt + DB_W'(1);
         end
      end
   end

endmodule

// File: rtl/key_count_source.sv
// Up/down/load count register driving bcd2driver, with a one-cycle changed flag.
module key_count_source
   import key_count_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_SIM,
   parameter int CNT_W           = CNT_W_DEFAULT,
   parameter int MAX_COUNT       = 127,
   parameter int WRAP            = 0
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             key_up_n,
   input  logic             key_down_n,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic [CNT_W-1:0] count,
   output logic             changed
);

   localparam logic [CNT_W-1:0] MAX_C      = CNT_W'(MAX_COUNT);
   localparam bit               NEED_CLAMP = (MAX_COUNT < (2**CNT_W - 1));

   logic             up_press, down_press;
   logic             up_level_unused, down_level_unused;
   logic [CNT_W-1:0] load_clamped;
   logic [CNT_W-1:0] count_next;

   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up (
      .clock       (clock),
      .reset_n     (reset_n),
      .raw_n       (key_up_n),
      .level       (up_level_unused),
      .press_pulse (up_press)
   );

   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_down (
      .clock       (clock),
      .reset_n     (reset_n),
      .raw_n       (key_down_n),
      .level       (down_level_unused),
      .press_pulse (down_press)
   );

   generate
      if (NEED_CLAMP) begin : g_clamp
         assign load_clamped = (load_val > MAX_C) ? MAX_C : load_val;
      end else begin : g_noclamp
         assign load_clamped = load_val;
      end
   endgenerate

   // Boundary tests come before the +/-1 so a MAX_COUNT below the full range
   // never wraps through the unused codes.
   always_comb begin
      count_next = count;
      if (load) begin
         count_next = load_clamped;
      end else if (up_press && down_press) begin
         count_next = count;
      end else if (up_press) begin
         if (count == MAX_C) count_next = (WRAP != 0) ? '0 : count;
         else                count_next = count + CNT_W'(1);
      end else if (down_press) begin
         if (count == '0)    count_next = (WRAP != 0) ? MAX_C : count;
         else                count_next = count - CNT_W'(1);
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         count   <= '0;
         changed <= 1'b0;
      end else begin
         count   <= count_next;
         changed <= (count_next != count);
      end
   end

endmodule

// File: tb/tb_key_count_source.sv
// Directed and random stimulus on two instances (saturate and wrap), checked
// against a behavioural model of the key-to-count path.
module tb_key_count_source;

   localparam int D   = 4;
   localparam int W   = 7;
   localparam int MAX = 127;

   logic         clock = 1'b0;
   logic         reset_n = 1'b0;
   logic         key_up_n = 1'b1;
   logic         key_down_n = 1'b1;
   logic         load = 1'b0;
   logic [W-1:0] load_val = '0;
   logic [W-1:0] count0, count1;
   logic         changed0, changed1;

   int checks = 0;
   int errors = 0;

   key_count_source #(.DEBOUNCE_CYCLES(D), .CNT_W(W), .MAX_COUNT(MAX), .WRAP(0)) dut0 (
      .clock(clock), .reset_n(reset_n), .key_up_n(key_up_n), .key_down_n(key_down_n),
      .load(load), .load_val(load_val), .count(count0), .changed(changed0));

   key_count_source #(.DEBOUNCE_CYCLES(D), .CNT_W(W), .MAX_COUNT(MAX), .WRAP(1)) dut1 (
      .clock(clock), .reset_n(reset_n), .key_up_n(key_up_n), .key_down_n(key_down_n),
      .load(load), .load_val(load_val), .count(count1), .changed(changed1));

   always #5 clock = ~clock;

   // Model: index [w] is the wrap setting, index [k] is 0=up, 1=down.
   int mc [2];
   bit mch [2];
   bit dly1 [2], dly2 [2], mstable [2];
   int run [2];
   bit mpress [2];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         mc[i] = 0; mch[i] = 0; dly1[i] = 1; dly2[i] = 1;
         mstable[i] = 1; run[i] = 0; mpress[i] = 0;
      end
   endtask

   // One clock edge: the count reacts to press events detected on the
   // previous edge; a key press is recognised once the twice-delayed raw
   // level has disagreed with the accepted level for D consecutive edges.
   task automatic model_step();
      bit raw [2];
      bit newp [2];
      bit s2u;
      int oldc, newc;
      raw[0] = key_up_n; raw[1] = key_down_n;
      for (int w = 0; w < 2; w++) begin
         oldc = mc[w];
         newc = oldc;
         if (load) newc = (int'(load_val) > MAX) ? MAX : int'(load_val);
         else if (mpress[0] && mpress[1]) newc = oldc;
         else if (mpress[0]) newc = (oldc == MAX) ? ((w == 1) ? 0 : MAX) : oldc + 1;
         else if (mpress[1]) newc = (oldc == 0) ? ((w == 1) ? MAX : 0) : oldc - 1;
         mch[w] = (newc != oldc);
         mc[w]  = newc;
      end
      for (int k = 0; k < 2; k++) begin
         newp[k] = 0;
         s2u = dly2[k];
         dly2[k] = dly1[k];
         dly1[k] = raw[k];
         if (s2u != mstable[k]) begin
            run[k]++;
            if (run[k] == D) begin
               mstable[k] = s2u;
               run[k] = 0;
               newp[k] = (s2u == 0);
            end
         end else begin
            run[k] = 0;
         end
      end
      mpress[0] = newp[0];
      mpress[1] = newp[1];
   endtask

   task automatic cycle();
      @(posedge clock);
      #1;
      model_step();
      chk("count_sat", count0, mc[0]);
      chk("changed_sat", changed0, mch[0]);
      chk("count_wrap", count1, mc[1]);
      chk("changed_wrap", changed1, mch[1]);
   endtask

   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      key_up_n = 1'b1; key_down_n = 1'b1; load = 1'b0;
      model_reset();
      @(negedge clock);
      reset_n = 1'b1;
   endtask

   task automatic press(input bit up, input bit down, input int len);
      key_up_n = ~up; key_down_n = ~down;
      cycles(len);
      key_up_n = 1'b1; key_down_n = 1'b1;
      cycles(D + 4);
   endtask

   task automatic load_value(input int v);
      load = 1'b1; load_val = W'(v);
      cycle();
      load = 1'b0;
      cycles(1);
   endtask

   initial begin
      model_reset();
      #12;
      #1;
      chk("reset_count", count0, 0);
      chk("reset_changed", changed0, 0);
      @(negedge clock);
      reset_n = 1'b1;

      // idle
      for (int i = 0; i < 10; i++) begin
         cycle();
         chk("idle_count", count0, 0);
         chk("idle_changed", changed0, 0);
      end

      // latency: raw low before edge 1, count moves on edge 7
      do_reset();
      key_up_n = 1'b0;
      cycles(6);
      chk("latency_pre", count0, 0);
      cycle();
      chk("latency_edge7", count0, 1);
      chk("latency_changed", changed0, 1);
      cycles(13);
      chk("no_repeat", count0, 1);
      key_up_n = 1'b1;
      cycles(D + 4);

      // bounce rejected, then clean press
      do_reset();
      key_up_n = 1'b0; cycles(2);
      key_up_n = 1'b1; cycles(2);
      key_up_n = 1'b0; cycles(2);
      key_up_n = 1'b1; cycles(D + 4);
      chk("bounce_rejected", count0, 0);
      press(1, 0, 10);
      chk("clean_press", count0, 1);

      // load, up, down, down
      load_value(22);
      chk("load22", count0, 22);
      press(1, 0, 8);
      chk("up_23", count0, 23);
      press(0, 1, 8);
      press(0, 1, 8);
      chk("down_21", count0, 21);

      // saturation vs wrap at the top
      load_value(127);
      key_up_n = 1'b0;
      for (int i = 0; i < 10; i++) begin
         cycle();
         chk("sat_top_changed", changed0, 0);
      end
      key_up_n = 1'b1;
      cycles(D + 4);
      chk("sat_top", count0, 127);
      chk("wrap_top", count1, 0);

      // saturation vs wrap at the bottom
      load_value(0);
      press(0, 1, 8);
      chk("sat_bottom", count0, 0);
      chk("wrap_bottom", count1, 127);

      // both keys together
      load_value(50);
      press(1, 1, 8);
      chk("both_keys", count0, 50);

      // load wins over a coincident press pulse
      key_up_n = 1'b0;
      cycles(6);
      load = 1'b1; load_val = W'(99);
      cycle();
      load = 1'b0;
      chk("load_over_press", count0, 99);
      key_up_n = 1'b1;
      cycles(D + 4);
      chk("load_over_press_hold", count0, 99);

      // asynchronous reset mid-count and mid-debounce
      load_value(37);
      chk("pre_reset37", count0, 37);
      key_up_n = 1'b0;
      cycles(3);
      @(posedge clock);
      #2;
      reset_n = 1'b0;
      #1;
      chk("async_reset_sat", count0, 0);
      chk("async_reset_wrap", count1, 0);
      model_reset();
      @(negedge clock);
      reset_n = 1'b1;
      cycles(6);
      chk("reset_discards_progress", count0, 0);
      cycle();
      chk("post_reset_press", count0, 1);
      key_up_n = 1'b1;
      cycles(D + 4);

      // randomized key levels and occasional loads
      for (int r = 0; r < 300; r++) begin
         int len;
         key_up_n   = ($urandom_range(0, 2) != 0);
         key_down_n = ($urandom_range(0, 2) != 0);
         len = $urandom_range(1, 10);
         for (int c = 0; c < len; c++) begin
            load = ($urandom_range(0, 19) == 0);
            load_val = W'($urandom_range(0, 127));
            cycle();
         end
         load = 1'b0;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/key_count_source.md
Name: key_count_source

Overview:
- Upstream stage of bcd2driver. Produces the 7-bit binary value that bcd2driver converts to HEX1/HEX0 and gt99.
- Takes two active-low pushbuttons (up, down) and a switch-load path. Synchronizes and debounces each button, detects presses, and keeps a 7-bit count.
- Sits between the board KEY/SW inputs and bcd2driver's `in` port.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive stable samples needed to accept a button level change (use 4 in sim, 500000 on board).
- CNT_W, 7: count width; matches bcd2driver input.
- MAX_COUNT, 127: upper count limit; must be at most 2^CNT_W-1.
- WRAP, 0: 0 = saturate at 0 and MAX_COUNT; 1 = wrap MAX_COUNT->0 and 0->MAX_COUNT.

Ports:
- clock, input, 1: single system clock, rising edge.
- reset_n, input, 1: asynchronous, active-low reset.
- key_up_n, input, 1: raw active-low up button; asynchronous to clock.
- key_down_n, input, 1: raw active-low down button; asynchronous to clock.
- load, input, 1: synchronous load strobe; level-sampled each cycle.
- load_val, input, CNT_W: load value (SW[6:0]).
- count, output, CNT_W: current count; connects to bcd2driver `in`.
- changed, output, 1: one-cycle pulse when count takes a new value.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - count=0, changed=0.
  - Synchronizer flops=1 and debounced levels=1 (released).
  - Debounce counters=0.
  - Deassertion mid-debounce discards all partial debounce progress.
- Synchronizer: each key passes through 2 flops (s1, s2). Only s2 is used downstream.
- Debounce, per key:
  - If s2 equals the stable level, clear the counter.
  - Otherwise increment the counter. When it reaches DEBOUNCE_CYCLES-1 while s2 still differs, stable takes s2 and the counter clears.
  - Any return to the stable level before then clears the counter: bounce shorter than DEBOUNCE_CYCLES is rejected.
- Press detect: a 1->0 transition of stable produces a registered one-cycle press pulse. Release (0->1) produces nothing.
- Latency: a raw key held low from before edge 1 updates count on edge DEBOUNCE_CYCLES+3 (2 sync + DEBOUNCE_CYCLES debounce + 1 update). This is exactly 7 edges with the default.
- Count update priority, each edge:
  1. load=1: count=load_val, clamped to MAX_COUNT if larger. Any same-cycle press pulse is dropped.
  2. Up and down pulses in the same cycle: no change.
  3. Up pulse: count+1. If at MAX_COUNT, hold (WRAP=0) or go to 0 (WRAP=1).
  4. Down pulse: count-1. If at 0, hold (WRAP=0) or go to MAX_COUNT (WRAP=1).
- Holding a key gives exactly one increment; there is no auto-repeat.
- changed=1 for the one cycle after count's registered value differs from its previous value.
  - Saturation holds and loads of an equal value do not pulse.
- Arithmetic: CNT_W-bit unsigned. Compute the boundary test before the ±1, so there is no silent modulo-2^CNT_W wrap when MAX_COUNT < 2^CNT_W-1.

Decomposition:
- Shared package (key_count_pkg):
  - CNT_W default.
  - SYNC_STAGES=2.
  - KEY_RELEASED=1'b1 constant.
  - Sim and board DEBOUNCE_CYCLES constants.
- Sub-module key_debounce: clock, reset_n, raw_n in; level, press_pulse out. Instantiated twice.
  - Contains the synchronizer, debounce counter (width $clog2(DEBOUNCE_CYCLES)+1), and edge detect.
- Top key_count_source holds the count register, priority logic and changed generation.

Test Plan:
- Reset, then 10 idle cycles -> count=0, changed never asserts. Assert reset_n=0 mid-count at count=37 -> count=0 immediately, without waiting for a clock edge.
- key_up_n low from edge 1, held 20 cycles, DEBOUNCE_CYCLES=4 -> count 0->1 at edge 7. changed pulses one cycle. No further increment while held.
- key_up_n low for 2 cycles, high 2, low 2 (bounce) -> count stays 0. Then a clean 10-cycle press -> count=1.
- load=1 with load_val=22 -> count=22 next edge. Then up press -> 23. Then down press twice -> 21.
- Saturation and wrap:
  - WRAP=0, load 127, up press -> count stays 127 and changed stays 0.
  - WRAP=0, load 0, down press -> count stays 0.
  - WRAP=1, same stimulus -> 127->0 and 0->127.
- Simultaneous events:
  - Both keys pressed with identical timing -> count unchanged.
  - Up press pulse coincident with load=1, load_val=99 -> count=99, not 100.
